// File: rtl/seq_divider_if.sv
// +-----------------------------------------------------------------------------
// | seq_divider_if : request/result bundle between control unit and divider
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// +-----------------------------------------------------------------------------
// | seq_divider : iterative non-restoring divider, one quotient bit per clock
// | Signed mode enabled by defining SEQ_DIVIDER_SIGNED_EN (default: unsigned)
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    clr_n,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_ZDIV = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH:0]   r_p, w_p_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_m, w_m_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_dbz, w_dbz_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;

    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_p_sh, w_p_step, w_p_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign w_a_neg = bus.dividend[WIDTH-1];
    assign w_b_neg = bus.divisor[WIDTH-1];
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
`endif

    // |MIN| still fits because magnitudes are treated as unsigned
    assign w_a_mag = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_mag = w_b_neg ? -bus.divisor  : bus.divisor;

    assign w_p_sh   = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_p_step = r_p[WIDTH] ? (w_p_sh + {1'b0, r_m}) : (w_p_sh - {1'b0, r_m});
    assign w_p_fix  = r_p[WIDTH] ? (r_p + {1'b0, r_m}) : r_p;

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_q_nxt     = r_q;
        w_m_nxt     = r_m;
        w_cnt_nxt   = r_cnt;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_dbz_nxt   = r_dbz;
        w_quo_nxt   = r_quo;
        w_rem_nxt   = r_rem;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_p_nxt     = '0;
                    w_m_nxt     = w_b_mag;
                    w_cnt_nxt   = CNT_W'(WIDTH);
                    w_neg_q_nxt = w_a_neg ^ w_b_neg;
                    w_neg_r_nxt = w_a_neg;
                    w_busy_nxt  = 1'b1;
                    w_dbz_nxt   = 1'b0;
                    // Divide-by-zero keeps the raw dividend for the remainder
                    if (bus.divisor == '0) begin
                        w_q_nxt     = bus.dividend;
                        w_state_nxt = S_ZDIV;
                    end else begin
                        w_q_nxt     = w_a_mag;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_p_nxt   = w_p_step;
                w_q_nxt   = {r_q[WIDTH-2:0], ~w_p_step[WIDTH]};
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_p_nxt     = w_p_fix;
                w_quo_nxt   = r_neg_q ? -r_q : r_q;
                w_rem_nxt   = r_neg_r ? -w_p_fix[WIDTH-1:0] : w_p_fix[WIDTH-1:0];
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            S_ZDIV: begin
                w_quo_nxt   = '1;
                w_rem_nxt   = r_q;
                w_dbz_nxt   = 1'b1;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_p     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
        end else begin
            r_p     <= w_p_nxt;
            r_q     <= w_q_nxt;
            r_m     <= w_m_nxt;
            r_cnt   <= w_cnt_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dbz   <= w_dbz_nxt;
            r_quo   <= w_quo_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rem;
endmodule

`default_nettype wire
